// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and defaults for the IF-stage program counter / fetch controller.
package pc_fetch_ctrl_pkg;

  localparam int          DEF_ADDR_WIDTH   = 32;
  localparam int          DEF_INST_WIDTH   = 32;
  localparam int          DEF_INST_BYTES   = 4;
  localparam logic [63:0] DEF_RESET_VECTOR = 64'h0;

  typedef enum logic [1:0] {
    ST_RESET_HOLD,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } state_t;

  // Mask that clears the byte-offset bits of an instruction address.
  function automatic logic [63:0] align_mask(input int inst_bytes);
    return ~(64'(inst_bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Program counter and single-outstanding instruction fetch controller with
// stall, redirect and a req/gnt/rvalid memory handshake.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int                    INST_WIDTH   = DEF_INST_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEF_RESET_VECTOR),
  parameter int                    INST_BYTES   = DEF_INST_BYTES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [INST_WIDTH-1:0] mem_rdata_i,
  output logic                  fetch_en_o,
  output logic                  if_valid_o,
  output logic [ADDR_WIDTH-1:0] if_pc_o,
  output logic [INST_WIDTH-1:0] if_inst_o
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(align_mask(INST_BYTES));
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INST_BYTES);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic                    kill_q;
  logic [ADDR_WIDTH-1:0]   redirect_target;
  logic                    capture;
  logic                    release_hold;

  assign redirect_target = redirect_pc_i & ALIGN_MASK;
  assign capture      = (state_q == ST_WAIT) && mem_rvalid_i && !kill_q && !redirect_valid_i;
  assign release_hold = (state_q == ST_HOLD) && (redirect_valid_i || !stall_i);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of block order.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_RESET_HOLD;
    else       state_q <= state_d;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET_HOLD: state_d = ST_REQ;
      ST_REQ:        if (mem_gnt_i) state_d = ST_WAIT;
      ST_WAIT:       if (mem_rvalid_i) state_d = (kill_q || redirect_valid_i) ? ST_REQ : ST_HOLD;
      ST_HOLD:       if (redirect_valid_i || !stall_i) state_d = ST_REQ;
      default:       state_d = ST_RESET_HOLD;
    endcase
  end

  // Reset gates the request so nothing is issued while the old state drains.
  always_comb begin
    mem_req_o  = (state_q == ST_REQ) && !reset;
    mem_addr_o = pc_q;
  end

  // kill marks a response in flight that belongs to a squashed PC.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q   <= RESET_VECTOR;
      kill_q <= 1'b0;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (redirect_valid_i) begin
            pc_q <= redirect_target;
            if (mem_gnt_i) kill_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid_i) begin
            kill_q <= 1'b0;
            if (redirect_valid_i) pc_q <= redirect_target;
            else if (!kill_q)     pc_q <= pc_q + PC_STEP;
          end else if (redirect_valid_i) begin
            pc_q   <= redirect_target;
            kill_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (redirect_valid_i) pc_q <= redirect_target;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_en_o <= 1'b0;
      if_valid_o <= 1'b0;
      if_pc_o    <= '0;
      if_inst_o  <= '0;
    end else begin
      if (state_q == ST_RESET_HOLD) fetch_en_o <= 1'b1;
      if (capture) begin
        if_valid_o <= 1'b1;
        if_pc_o    <= pc_q;
        if_inst_o  <= mem_rdata_i;
      end else if (release_hold) begin
        if_valid_o <= 1'b0;
      end
    end
  end

  // A response arriving outside WAIT must never reach the IF/ID register.
  a_rvalid_ignored: assert property (@(posedge clock) disable iff (reset)
    (mem_rvalid_i && state_q != ST_WAIT) |=> $stable(if_inst_o));

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Parametrised program-counter and instruction-fetch controller for the IF stage. It replaces a free-running PC+4 counter with one that supports stall, branch/jump redirect, and a req/gnt/rvalid handshake to the instruction memory, with a single outstanding fetch. It presents one fetched instruction and its PC to the IF/ID boundary and holds it while the pipeline stalls.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address
INST_WIDTH, 32, width of fetched instruction word
RESET_VECTOR, 0, first fetch address after reset
INST_BYTES, 4, PC increment and alignment; power of two

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-high reset
stall_i  input  1  downstream cannot accept held instruction
redirect_valid_i  input  1  branch/jump/exception redirect request
redirect_pc_i  input  ADDR_WIDTH  redirect target
mem_req_o  output  1  fetch request
mem_addr_o  output  ADDR_WIDTH  fetch address, valid while mem_req_o=1
mem_gnt_i  input  1  memory accepted request this cycle
mem_rvalid_i  input  1  read data valid
mem_rdata_i  input  INST_WIDTH  read data
fetch_en_o  output  1  high once out of post-reset hold
if_valid_o  output  1  instruction held at output
if_pc_o  output  ADDR_WIDTH  PC of held instruction
if_inst_o  output  INST_WIDTH  held instruction

Behaviour:
- Reset: clock is clock; reset is reset, synchronous, active-high. On reset: state=RESET_HOLD, pc=RESET_VECTOR, kill=0, fetch_en_o=0, if_valid_o=0, if_pc_o=0, if_inst_o=0. mem_req_o=0 during reset.
- mem_req_o = (state==REQ), combinational decode. mem_addr_o = pc.
- Redirect target aligned: low log2(INST_BYTES) bits forced to 0. PC arithmetic wraps modulo 2^ADDR_WIDTH.
- Redirect has priority over stall in every state.
- RESET_HOLD: one cycle, then REQ. fetch_en_o<=1 on leaving.
- REQ:
  - gnt with no redirect: go to WAIT.
  - Redirect with no gnt: pc<=target; stay in REQ. The address changes next cycle; memory samples the address only on gnt.
  - Redirect and gnt in the same cycle: the old-PC fetch is in flight. Set pc<=target, kill<=1, go to WAIT.
- WAIT:
  - No rvalid, redirect: pc<=target, kill<=1.
  - rvalid with kill=1 or redirect: discard data, kill<=0, pc<=target if redirect else unchanged, go to REQ.
  - rvalid, kill=0, no redirect: if_valid_o<=1, if_pc_o<=pc, if_inst_o<=mem_rdata_i, pc<=pc+INST_BYTES, go to HOLD.
- HOLD (if_valid_o=1):
  - Redirect: if_valid_o<=0, pc<=target, go to REQ.
  - Else if stall_i=0: the instruction is consumed this cycle; if_valid_o<=0, go to REQ.
  - Else: hold all outputs.
- mem_rvalid_i outside WAIT is ignored (assertion-checked).
- Only one outstanding transaction.
- Best-case throughput: 1 instruction per 3 cycles (REQ, WAIT, HOLD).
- Latency: reset deasserted at cycle 0. Cycle 1: REQ at RESET_VECTOR. With gnt in cycle 1 and rvalid in cycle 2, if_valid_o=1 in cycle 3.
- Reset mid-fetch: transaction abandoned; later rvalid ignored (state≠WAIT). The memory model must tolerate this.
- stall_i is don't-care outside HOLD.

Decomposition:
- Shared package: state enum {RESET_HOLD, REQ, WAIT, HOLD}; default ADDR_WIDTH/INST_WIDTH/INST_BYTES/RESET_VECTOR constants; align-mask function.
- No sub-module needed; single always block for state/pc/kill plus output register block.

Test Plan:
- Reset, then gnt immediate, rvalid next cycle, stall=0 → fetch addresses 0x0, 0x4, 0x8; if_valid pulses with matching if_pc; first if_valid in cycle 3.
- RESET_VECTOR=0x80000000, pc at 0xFFFFFFFC with ADDR_WIDTH=32 → next fetch 0x00000000 (wrap).
- stall_i=1 for 5 cycles in HOLD → if_valid/if_pc/if_inst stable, mem_req_o=0; release → REQ next cycle at pc+4.
- Redirect to 0x103 in WAIT before rvalid → returned data discarded (if_valid stays 0), next request at 0x100.
- Redirect with gnt in the same REQ cycle → old response dropped, next mem_addr_o=target; redirect in HOLD with stall=1 → if_valid drops, request at target.
- Assert reset while in WAIT, then deliver rvalid 2 cycles later → no if_valid, fetch restarts at RESET_VECTOR after the RESET_HOLD cycle.
